tff_count_sequencer: RTL and testbench

//  Run/stop controller for a bank of WIDTH T flip-flops that form a modulo up/down counter.

---
 rtl/tff_count_sequencer.sv | 91 +++++++++
 tb/tb_tff_count_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/tff_count_sequencer.sv
// Run/stop sequencer for a WIDTH-bit T flip-flop bank counting modulo (lim_r+1) up or down.
// Adds load, pause, one-shot completion and terminal-count pulses around the bank.
module tff_count_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             up_dn,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] lim_r, q_nx, step_val;
  logic             dir_r, os_r, wrap, tc_nx;

  always_comb begin
    wrap = dir_r ? (q >= lim_r) : (q == '0);
    if (dir_r) step_val = wrap ? '0    : q + WIDTH'(1);
    else       step_val = wrap ? lim_r : q - WIDTH'(1);

    state_nx = state;
    q_nx     = q;
    tc_nx    = 1'b0;
    case (state)
      IDLE: begin
        // start wins over load: counting begins from the current q
        if (start)     state_nx = RUN;
        else if (load) q_nx     = load_val;
      end
      RUN: begin
        if (stop)      state_nx = IDLE;
        else if (hold) state_nx = PAUSE;
        else begin
          q_nx = step_val;
          if (wrap) begin
            tc_nx = 1'b1;
            if (os_r) state_nx = DONE;
          end
        end
      end
      PAUSE: begin
        if (stop)       state_nx = IDLE;
        else if (load)  q_nx     = load_val;
        else if (!hold) state_nx = RUN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Toggle mask for the T-FF bank: exactly the bits that flip at the next edge
    t_vec = q ^ q_nx;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      q     <= '0;
      lim_r <= '0;
      dir_r <= 1'b1;
      os_r  <= 1'b0;
      busy  <= 1'b0;
      tc    <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q ^ t_vec;
      tc    <= tc_nx;
      busy  <= (state_nx == RUN) || (state_nx == PAUSE);
      done  <= (state_nx == DONE);
      if (state == IDLE && start) begin
        lim_r <= limit;
        dir_r <= up_dn;
        os_r  <= oneshot;
      end
    end
  end

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer (WIDTH=4) with hand-computed expected values.
module tb_tff_count_sequencer;

  logic       clk, clr, start, stop, hold, load, up_dn, oneshot;
  logic [3:0] load_val, limit, q, t_vec;
  logic       busy, tc, done;

  int n_checks = 0;
  int n_errors = 0;

  tff_count_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .hold(hold), .load(load),
    .load_val(load_val), .limit(limit), .up_dn(up_dn), .oneshot(oneshot),
    .q(q), .t_vec(t_vec), .busy(busy), .tc(tc), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input int eq, input int ebusy, input int etc, input int edone);
    check_val({tag, "_q"},    32'(q),    32'(eq));
    check_val({tag, "_busy"}, 32'(busy), 32'(ebusy));
    check_val({tag, "_tc"},   32'(tc),   32'(etc));
    check_val({tag, "_done"}, 32'(done), 32'(edone));
  endtask

  task automatic chk_tvec(input string tag, input int et);
    #1;
    check_val(tag, 32'(t_vec), 32'(et));
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; load = 1'b0;
    up_dn = 1'b0; oneshot = 1'b0; load_val = 4'd0; limit = 4'd0;
    #12;
    chk("reset", 0, 0, 0, 0);
    chk_tvec("reset_tvec", 0);
    @(negedge clk);
    clr = 1'b1;
    tick;

    // 1: up count modulo 6, free running
    limit = 4'd5; up_dn = 1'b1; oneshot = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    chk("t1_start", 0, 1, 0, 0);
    chk_tvec("t1_tvec", 1);
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk("t1_run", k % 6, 1, (k % 6 == 0) ? 1 : 0, 0);
    end
    stop = 1'b1; tick; stop = 1'b0;
    chk("t1_stop", 2, 0, 0, 0);

    // 2: down count modulo 10 from a loaded 3
    limit = 4'd9; up_dn = 1'b0; load_val = 4'd3; load = 1'b1;
    chk_tvec("t2_load_tvec", 1);
    tick; load = 1'b0;
    chk("t2_load", 3, 0, 0, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("t2_start", 3, 1, 0, 0);
    tick; chk("t2_2", 2, 1, 0, 0);
    tick; chk("t2_1", 1, 1, 0, 0);
    tick; chk("t2_0", 0, 1, 0, 0);
    chk_tvec("t2_wrap_tvec", 9);
    tick; chk("t2_9", 9, 1, 1, 0);
    tick; chk("t2_8", 8, 1, 0, 0);
    stop = 1'b1; tick; stop = 1'b0;
    chk("t2_stop", 8, 0, 0, 0);

    // 3: one-shot up count to 3, then restart
    load_val = 4'd0; load = 1'b1; tick; load = 1'b0;
    limit = 4'd3; up_dn = 1'b1; oneshot = 1'b1; start = 1'b1;
    tick; start = 1'b0;
    chk("t3_start", 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      tick;
      chk("t3_run", k, 1, 0, 0);
    end
    tick; chk("t3_done", 0, 0, 1, 1);
    tick; chk("t3_idle", 0, 0, 0, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("t3_restart", 0, 1, 0, 0);
    tick; chk("t3_restart1", 1, 1, 0, 0);
    stop = 1'b1; tick; stop = 1'b0;

    // 4: hold / pause with load
    load_val = 4'd6; load = 1'b1; tick; load = 1'b0;
    limit = 4'd9; up_dn = 1'b1; oneshot = 1'b0; start = 1'b1;
    tick; start = 1'b0;
    chk("t4_start", 6, 1, 0, 0);
    hold = 1'b1;
    chk_tvec("t4_hold_tvec", 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("t4_pause", 6, 1, 0, 0);
      chk_tvec("t4_pause_tvec", 0);
    end
    load_val = 4'd2; load = 1'b1;
    chk_tvec("t4_pload_tvec", 4);
    tick; load = 1'b0;
    chk("t4_pload", 2, 1, 0, 0);
    hold = 1'b0;
    tick; chk("t4_resume", 2, 1, 0, 0);
    tick; chk("t4_count", 3, 1, 0, 0);

    // 5: stop beats hold and load; load alone in RUN is ignored
    stop = 1'b1; hold = 1'b1; load = 1'b1; load_val = 4'd7;
    tick; stop = 1'b0; hold = 1'b0; load = 1'b0;
    chk("t5_stop", 3, 0, 0, 0);
    start = 1'b1; tick; start = 1'b0;
    chk("t5_start", 3, 1, 0, 0);
    load = 1'b1; load_val = 4'd10;
    chk_tvec("t5_run_load_tvec", 7);
    tick; load = 1'b0;
    chk("t5_run_load", 4, 1, 0, 0);

    // 6: limit 0 fires tc every cycle; async clear kills it mid-cycle
    stop = 1'b1; tick; stop = 1'b0;
    limit = 4'd0; load_val = 4'd0; load = 1'b1; tick; load = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    chk("t6_start", 0, 1, 0, 0);
    tick; chk("t6_tc_a", 0, 1, 1, 0);
    tick; chk("t6_tc_b", 0, 1, 1, 0);
    #2 clr = 1'b0;
    #1 chk("t6_clr", 0, 0, 0, 0);
    #1 clr = 1'b1;
    tick; chk("t6_after_a", 0, 0, 0, 0);
    tick; chk("t6_after_b", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
